// File: rtl/pacman_pkg.sv
// Shared encodings for the player movement scheduler and the tile-map arbiter.
package pacman_pkg;

  localparam int TILE_SHIFT_DEF = 4;
  localparam int MAP_COLS_DEF   = 40;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_PROBE0,
    ST_PROBE1,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/pacman_tile_addr.sv
// Pixel coordinate to row-major tile index of the shared wall map.
module pacman_tile_addr
  import pacman_pkg::*;
#(
  parameter int TILE_SHIFT = TILE_SHIFT_DEF,
  parameter int MAP_COLS   = MAP_COLS_DEF
) (
  input  logic [9:0]  px_i,
  input  logic [8:0]  py_i,
  output logic [10:0] addr_o
);

  logic [10:0] row;
  logic [10:0] col;

  assign row    = 11'(py_i >> TILE_SHIFT);
  assign col    = 11'(px_i >> TILE_SHIFT);
  assign addr_o = row * 11'(MAP_COLS) + col;

endmodule

// File: rtl/pacman_move_ctrl.sv
// Once-per-frame sprite mover: latches the PS/2 direction, probes the two
// leading-edge corner tiles of the candidate position and commits or falls back.
module pacman_move_ctrl
  import pacman_pkg::*;
#(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int TILE_SHIFT = TILE_SHIFT_DEF,
  parameter int MAP_COLS   = MAP_COLS_DEF,
  parameter int STEP       = 1,
  parameter int START_X    = 304,
  parameter int START_Y    = 224
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        vs,
  input  logic [7:0]  ps2_key_data,
  output logic        map_req,
  output logic [10:0] map_addr,
  input  logic        map_ack,
  input  logic        map_wall,
  output logic [9:0]  x_pos,
  output logic [8:0]  y_pos,
  output logic [1:0]  dir,
  output logic        moving,
  output logic        busy,
  output logic        overrun
);

  localparam logic signed [11:0] STEP_S  = 12'(STEP);
  localparam logic signed [11:0] SPR_W_S = 12'(SPRITE_W);
  localparam logic signed [11:0] SPR_H_S = 12'(SPRITE_H);
  localparam logic signed [11:0] SCR_W_S = 12'(SCREEN_W);
  localparam logic signed [11:0] SCR_H_S = 12'(SCREEN_H);
  localparam logic [9:0]         XOFF    = 10'(SPRITE_W - 1);
  localparam logic [8:0]         YOFF    = 9'(SPRITE_H - 1);

  state_e      state_q, state_d;
  logic        vsPrev_q, vsPrev_d;
  logic [1:0]  pendingDir_q, pendingDir_d;
  logic [1:0]  tryDir_q, tryDir_d;
  logic [1:0]  dir_q, dir_d;
  logic [9:0]  x_q, x_d, candX_q, candX_d;
  logic [8:0]  y_q, y_d, candY_q, candY_d;
  logic [10:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic        moving_q, moving_d;
  logic        overrun_q, overrun_d;

  logic               tick;
  logic               blocked;
  logic               outOfBounds;
  logic signed [11:0] xs, ys, nx, ny;
  logic [9:0]         xl, xr, c0x, c1x;
  logic [8:0]         yt, yb, c0y, c1y;
  logic [10:0]        cornerAddr0, cornerAddr1;

  assign tick = vsPrev_q & ~vs;
  assign xs   = $signed({2'b00, x_q});
  assign ys   = $signed({3'b000, y_q});

  // Candidate position is computed one bit wider than the screen so a step
  // past either edge shows up as negative or too large rather than wrapping.
  always_comb begin
    nx = xs;
    ny = ys;
    case (tryDir_q)
      DIR_RIGHT: nx = xs + STEP_S;
      DIR_UP:    ny = ys - STEP_S;
      DIR_LEFT:  nx = xs - STEP_S;
      default:   ny = ys + STEP_S;
    endcase
  end

  assign outOfBounds = nx[11] || ny[11] ||
                       (nx + SPR_W_S > SCR_W_S) || (ny + SPR_H_S > SCR_H_S);

  assign xl = nx[9:0];
  assign xr = nx[9:0] + XOFF;
  assign yt = ny[8:0];
  assign yb = ny[8:0] + YOFF;

  always_comb begin
    c0x = xl;
    c0y = yt;
    c1x = xl;
    c1y = yt;
    case (tryDir_q)
      DIR_RIGHT: begin c0x = xr; c1x = xr; c1y = yb; end
      DIR_UP:    begin c1x = xr; end
      DIR_LEFT:  begin c1y = yb; end
      default:   begin c0y = yb; c1x = xr; c1y = yb; end
    endcase
  end

  pacman_tile_addr #(.TILE_SHIFT(TILE_SHIFT), .MAP_COLS(MAP_COLS)) u_corner0 (
    .px_i   (c0x),
    .py_i   (c0y),
    .addr_o (cornerAddr0)
  );

  pacman_tile_addr #(.TILE_SHIFT(TILE_SHIFT), .MAP_COLS(MAP_COLS)) u_corner1 (
    .px_i   (c1x),
    .py_i   (c1y),
    .addr_o (cornerAddr1)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      vsPrev_q     <= 1'b1;
      pendingDir_q <= DIR_RIGHT;
      tryDir_q     <= DIR_RIGHT;
      dir_q        <= DIR_RIGHT;
      x_q          <= 10'(START_X);
      y_q          <= 9'(START_Y);
      candX_q      <= 10'(START_X);
      candY_q      <= 9'(START_Y);
      addr0_q      <= '0;
      addr1_q      <= '0;
      moving_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsPrev_q     <= vsPrev_d;
      pendingDir_q <= pendingDir_d;
      tryDir_q     <= tryDir_d;
      dir_q        <= dir_d;
      x_q          <= x_d;
      y_q          <= y_d;
      candX_q      <= candX_d;
      candY_q      <= candY_d;
      addr0_q      <= addr0_d;
      addr1_q      <= addr1_d;
      moving_q     <= moving_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vsPrev_d     = vs;
    pendingDir_d = pendingDir_q;
    tryDir_d     = tryDir_q;
    dir_d        = dir_q;
    x_d          = x_q;
    y_d          = y_q;
    candX_d      = candX_q;
    candY_d      = candY_q;
    addr0_d      = addr0_q;
    addr1_d      = addr1_q;
    moving_d     = moving_q;
    overrun_d    = tick && (state_q != ST_IDLE);
    blocked      = 1'b0;

    case (ps2_key_data)
      KEY_RIGHT: pendingDir_d = DIR_RIGHT;
      KEY_UP:    pendingDir_d = DIR_UP;
      KEY_LEFT:  pendingDir_d = DIR_LEFT;
      KEY_DOWN:  pendingDir_d = DIR_DOWN;
      default:   pendingDir_d = pendingDir_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          tryDir_d = pendingDir_q;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (outOfBounds) begin
          blocked = 1'b1;
        end else begin
          candX_d = nx[9:0];
          candY_d = ny[8:0];
          addr0_d = cornerAddr0;
          addr1_d = cornerAddr1;
          state_d = ST_PROBE0;
        end
      end
      ST_PROBE0: begin
        if (map_ack) begin
          if (map_wall) blocked = 1'b1;
          else          state_d = ST_PROBE1;
        end
      end
      ST_PROBE1: begin
        if (map_ack) begin
          if (map_wall) blocked = 1'b1;
          else          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        x_d      = candX_q;
        y_d      = candY_q;
        dir_d    = tryDir_q;
        moving_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A blocked requested turn falls back to the current heading once.
    if (blocked) begin
      if (tryDir_q != dir_q) begin
        tryDir_d = dir_q;
        state_d  = ST_CALC;
      end else begin
        moving_d = 1'b0;
        state_d  = ST_IDLE;
      end
    end
  end

  assign map_req  = (state_q == ST_PROBE0) || (state_q == ST_PROBE1);
  assign map_addr = (state_q == ST_PROBE1) ? addr1_q :
                    (state_q == ST_PROBE0) ? addr0_q : '0;
  assign busy     = (state_q != ST_IDLE);
  assign x_pos    = x_q;
  assign y_pos    = y_q;
  assign dir      = dir_q;
  assign moving   = moving_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl with a behavioural tile-map responder.
module tb_pacman_move_ctrl;

  logic        vga_clk;
  logic        reset;
  logic        vs;
  logic [7:0]  ps2_key_data;
  logic        map_req;
  logic [10:0] map_addr;
  logic        map_ack;
  logic        map_wall;
  logic [9:0]  x_pos;
  logic [8:0]  y_pos;
  logic [1:0]  dir;
  logic        moving;
  logic        busy;
  logic        overrun;

  int compared = 0;
  int failed   = 0;

  logic wallMap [0:2047];
  int   ackDelay = 0;
  int   waitCnt  = 0;
  logic forceAck = 1'b0;

  int hsCount   = 0;
  int reqCycles = 0;
  int ovCount   = 0;
  int hsAddr[$];

  typedef struct {
    logic [7:0] key;
    int         expX;
    int         expY;
    int         expDir;
    int         expMoving;
  } vec_t;

  vec_t vecs [7];

  pacman_move_ctrl dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .vs           (vs),
    .ps2_key_data (ps2_key_data),
    .map_req      (map_req),
    .map_addr     (map_addr),
    .map_ack      (map_ack),
    .map_wall     (map_wall),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .dir          (dir),
    .moving       (moving),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Map responder: acks after ackDelay wait cycles, zero means same cycle.
  assign map_ack  = forceAck | (map_req && (waitCnt == ackDelay));
  assign map_wall = map_req ? wallMap[map_addr] : 1'b0;

  always @(posedge vga_clk) begin
    if (map_req && !map_ack) waitCnt <= waitCnt + 1;
    else                     waitCnt <= 0;
  end

  always @(negedge vga_clk) begin
    if (map_req && map_ack) begin
      hsCount++;
      hsAddr.push_back(int'(map_addr));
    end
    if (map_req) reqCycles++;
    if (overrun) ovCount++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int qAt(input int i);
    return (hsAddr.size() > i) ? hsAddr[i] : -1;
  endfunction

  task automatic clearCounters();
    hsCount   = 0;
    reqCycles = 0;
    ovCount   = 0;
    hsAddr.delete();
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1 reset = 1'b0;
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(posedge vga_clk);
      #1;
    end
    if (!done) begin
      compared++;
      failed++;
      $display("[TB] FAIL idleTimeout: busy still %0d after 200 cycles", busy);
    end
  endtask

  task automatic frameTick();
    vs = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1 vs = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] key);
    ps2_key_data = key;
    @(posedge vga_clk);
    #1;
    clearCounters();
    frameTick();
    waitIdle();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) wallMap[i] = 1'b0;
    reset        = 1'b1;
    vs           = 1'b1;
    ps2_key_data = 8'h00;

    // Moves from (305,224) heading right, empty map.
    vecs[0] = '{8'h75, 305, 223, 1, 1};
    vecs[1] = '{8'h6B, 304, 223, 2, 1};
    vecs[2] = '{8'h72, 304, 224, 3, 1};
    vecs[3] = '{8'hF0, 304, 225, 3, 1};
    vecs[4] = '{8'h1C, 304, 226, 3, 1};
    vecs[5] = '{8'h74, 305, 226, 0, 1};
    vecs[6] = '{8'h74, 306, 226, 0, 1};

    doReset();
    checkOutput("rst_x", int'(x_pos), 304);
    checkOutput("rst_y", int'(y_pos), 224);
    checkOutput("rst_dir", int'(dir), 0);
    checkOutput("rst_moving", int'(moving), 0);
    checkOutput("rst_req", int'(map_req), 0);
    checkOutput("rst_addr", int'(map_addr), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_overrun", int'(overrun), 0);

    // Zero-wait move right: corners (336,224)->14*40+21=581, (336,255)->15*40+21=621.
    ps2_key_data = 8'h74;
    @(posedge vga_clk);
    #1;
    clearCounters();
    vs = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge vga_clk);
      #1;
      if (k == 2) vs = 1'b1;
      case (k)
        1: checkOutput("lat_busy_calc", int'(busy), 1);
        2: begin
             checkOutput("lat_req_p0", int'(map_req), 1);
             checkOutput("lat_addr_p0", int'(map_addr), 581);
           end
        3: checkOutput("lat_addr_p1", int'(map_addr), 621);
        4: checkOutput("lat_x_before", int'(x_pos), 304);
        default: checkOutput("lat_x_after", int'(x_pos), 305);
      endcase
    end
    checkOutput("lat_hs_count", hsCount, 2);
    checkOutput("lat_hs_addr0", qAt(0), 581);
    checkOutput("lat_hs_addr1", qAt(1), 621);
    checkOutput("lat_dir", int'(dir), 0);
    checkOutput("lat_moving", int'(moving), 1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].key);
      checkOutput($sformatf("vec%0d_x", i), int'(x_pos), vecs[i].expX);
      checkOutput($sformatf("vec%0d_y", i), int'(y_pos), vecs[i].expY);
      checkOutput($sformatf("vec%0d_dir", i), int'(dir), vecs[i].expDir);
      checkOutput($sformatf("vec%0d_moving", i), int'(moving), vecs[i].expMoving);
      checkOutput($sformatf("vec%0d_hs", i), hsCount, 2);
    end

    // Walk right from 306 to the last legal column 608 (608+32 == 640).
    for (int i = 0; i < 302; i++) applyStimulus(8'h74);
    checkOutput("edge_x_reached", int'(x_pos), 608);
    applyStimulus(8'h74);
    checkOutput("edge_req_cycles", reqCycles, 0);
    checkOutput("edge_x_held", int'(x_pos), 608);
    checkOutput("edge_moving", int'(moving), 0);
    checkOutput("edge_dir", int'(dir), 0);

    // Up blocked at (335,223) -> tile 13*40+20=540; falls back to right.
    doReset();
    wallMap[540] = 1'b1;
    applyStimulus(8'h75);
    checkOutput("wall_hs_count", hsCount, 4);
    checkOutput("wall_hs_addr0", qAt(0), 539);
    checkOutput("wall_hs_addr1", qAt(1), 540);
    checkOutput("wall_hs_addr2", qAt(2), 581);
    checkOutput("wall_hs_addr3", qAt(3), 621);
    checkOutput("wall_x", int'(x_pos), 305);
    checkOutput("wall_y", int'(y_pos), 224);
    checkOutput("wall_dir", int'(dir), 0);
    checkOutput("wall_moving", int'(moving), 1);
    wallMap[540] = 1'b0;

    // Seven wait cycles on each probe: commit lands at tick+19.
    doReset();
    ackDelay     = 7;
    ps2_key_data = 8'h74;
    @(posedge vga_clk);
    #1;
    vs = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(posedge vga_clk);
      #1;
      if (k == 2) vs = 1'b1;
      if (k >= 2 && k <= 8) begin
        checkOutput($sformatf("dly_req_p0_c%0d", k), int'(map_req), 1);
        checkOutput($sformatf("dly_addr_p0_c%0d", k), int'(map_addr), 581);
      end
      if (k >= 10 && k <= 16) begin
        checkOutput($sformatf("dly_req_p1_c%0d", k), int'(map_req), 1);
        checkOutput($sformatf("dly_addr_p1_c%0d", k), int'(map_addr), 621);
      end
      if (k == 18) checkOutput("dly_x_before", int'(x_pos), 304);
      if (k == 19) checkOutput("dly_x_after", int'(x_pos), 305);
    end

    // Second tick while in PROBE1 (ack delay 3: PROBE1 starts at tick+6).
    doReset();
    ackDelay = 3;
    ps2_key_data = 8'h74;
    @(posedge vga_clk);
    #1;
    clearCounters();
    vs = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge vga_clk);
      #1;
      if (k == 1) vs = 1'b1;
      if (k == 6) begin
        checkOutput("ovr_busy", int'(busy), 1);
        vs = 1'b0;
      end
      if (k == 7) begin
        checkOutput("ovr_pulse", int'(overrun), 1);
        vs = 1'b1;
      end
      if (k == 8) checkOutput("ovr_pulse_end", int'(overrun), 0);
    end
    waitIdle();
    repeat (20) @(posedge vga_clk);
    #1;
    checkOutput("ovr_count", ovCount, 1);
    checkOutput("ovr_single_commit", int'(x_pos), 305);
    checkOutput("ovr_idle", int'(busy), 0);

    // Reset while PROBE0 waits for a slow ack, then a stray late ack.
    ackDelay = 20;
    ps2_key_data = 8'h74;
    @(posedge vga_clk);
    #1;
    vs = 1'b0;
    repeat (2) begin
      @(posedge vga_clk);
      #1;
      vs = 1'b1;
    end
    checkOutput("rmid_req_before", int'(map_req), 1);
    reset = 1'b1;
    @(posedge vga_clk);
    #1;
    checkOutput("rmid_req_dropped", int'(map_req), 0);
    checkOutput("rmid_busy", int'(busy), 0);
    checkOutput("rmid_x", int'(x_pos), 304);
    checkOutput("rmid_y", int'(y_pos), 224);
    reset    = 1'b0;
    forceAck = 1'b1;
    repeat (2) @(posedge vga_clk);
    #1 forceAck = 1'b0;
    @(posedge vga_clk);
    #1;
    checkOutput("late_x", int'(x_pos), 304);
    checkOutput("late_y", int'(y_pos), 224);
    checkOutput("late_busy", int'(busy), 0);
    checkOutput("late_req", int'(map_req), 0);
    checkOutput("late_moving", int'(moving), 0);
    checkOutput("late_dir", int'(dir), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
